// File: rtl/dmem_if.sv
// dmem_if: one requester port of the data-memory arbiter (req: valid/write/addr/wdata/ready; rsp: valid/rdata); master = requester, slave = arbiter
interface dmem_if #(parameter int ADDR_W = 9, parameter int DATA_W = 32);
  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  modport master (output req_valid, req_write, req_addr, req_wdata, input req_ready, rsp_valid, rsp_rdata);
  modport slave (input req_valid, req_write, req_addr, req_wdata, output req_ready, rsp_valid, rsp_rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer for a 512x32 data memory; ports clk, reset, p0/p1 (dmem_if.slave), mem_addr/mem_wdata/mem_we out, mem_rdata in
module dmem_arbiter #(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 32,
  parameter int ARB_MODE  = 0,
  parameter int PRIO_INIT = 0
) (
  input  logic              clk,
  input  logic              reset,
  dmem_if.slave             p0,
  dmem_if.slave             p1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t            state;
  logic              rr, win_q, wr_q, g0, g1, rv0, rv1;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rd0, rd1;
  always_comb begin
    g0 = state == IDLE && !reset && p0.req_valid && (!p1.req_valid || ARB_MODE != 0 || !rr);
    g1 = state == IDLE && !reset && p1.req_valid && !g0;
  end
  assign p0.req_ready = g0;
  assign p1.req_ready = g1;
  assign p0.rsp_valid = rv0 && !reset;
  assign p1.rsp_valid = rv1 && !reset;
  assign p0.rsp_rdata = rd0;
  assign p1.rsp_rdata = rd1;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = state == BUSY && wr_q && !reset;
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rr      <= PRIO_INIT != 0;
      win_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rv0     <= 1'b0;
      rv1     <= 1'b0;
      rd0     <= '0;
      rd1     <= '0;
    end else begin
      rv0 <= 1'b0;
      rv1 <= 1'b0;
      if (state == IDLE) begin
        if (g0 || g1) begin
          state   <= BUSY;
          win_q   <= g1;
          wr_q    <= g1 ? p1.req_write : p0.req_write;
          addr_q  <= g1 ? p1.req_addr : p0.req_addr;
          wdata_q <= g1 ? p1.req_wdata : p0.req_wdata;
          if (ARB_MODE == 0) rr <= !g1;
        end
      end else begin
        state <= IDLE;
        rv0   <= !win_q;
        rv1   <= win_q;
        if (win_q) rd1 <= wr_q ? '0 : mem_rdata;
        else rd0 <= wr_q ? '0 : mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter (round-robin DUT plus a fixed-priority twin for ready checks)
module tb_dmem_arbiter;
  logic clk = 0, reset = 1, clr = 1;
  logic [8:0]  mem_addr, mem_addr2;
  logic [31:0] mem_wdata, mem_wdata2, mem_rdata, mem_rdata2;
  logic        mem_we, mem_we2;
  logic [31:0] mem [512];
  logic [31:0] mem2 [512];
  logic [31:0] ref_mem [512];
  int n_chk = 0, n_fail = 0, cyc = 0;
  dmem_if p0 ();
  dmem_if p1 ();
  dmem_if q0 ();
  dmem_if q1 ();
  always #5 clk = ~clk;
  dmem_arbiter #(.ARB_MODE(0), .PRIO_INIT(0)) dut (.clk(clk), .reset(reset), .p0(p0), .p1(p1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata));
  dmem_arbiter #(.ARB_MODE(1), .PRIO_INIT(0)) dut_fp (.clk(clk), .reset(reset), .p0(q0), .p1(q1),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_we(mem_we2), .mem_rdata(mem_rdata2));
  assign q0.req_valid = p0.req_valid;
  assign q0.req_write = p0.req_write;
  assign q0.req_addr  = p0.req_addr;
  assign q0.req_wdata = p0.req_wdata;
  assign q1.req_valid = p1.req_valid;
  assign q1.req_write = p1.req_write;
  assign q1.req_addr  = p1.req_addr;
  assign q1.req_wdata = p1.req_wdata;
  assign mem_rdata  = mem[mem_addr];
  assign mem_rdata2 = mem2[mem_addr2];
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 512; i++) begin
        mem[i]  <= '0;
        mem2[i] <= '0;
      end
    end else begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_we2) mem2[mem_addr2] <= mem_wdata2;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  typedef struct {
    bit port;
    bit wr;
    logic [8:0] addr;
    logic [31:0] wdata;
    int due;
  } acc_t;
  acc_t sb[$];
  acc_t e;
  logic [31:0] exp_d;
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (clr) begin
      for (int i = 0; i < 512; i++) ref_mem[i] = '0;
    end else if (reset) begin
      sb.delete();
    end else begin
      if (p0.rsp_valid || p1.rsp_valid) begin
        if (sb.size() == 0) chk("unexpected_rsp", 1, 0);
        else begin
          e = sb.pop_front();
          exp_d = e.wr ? 32'h0 : ref_mem[e.addr];
          if (e.wr) ref_mem[e.addr] = e.wdata;
          chk("rsp_port", {31'b0, p1.rsp_valid}, {31'b0, e.port});
          chk("rsp_cycle", cyc, e.due);
          chk("rsp_data", e.port ? p1.rsp_rdata : p0.rsp_rdata, exp_d);
        end
      end else if (sb.size() > 0 && cyc >= sb[0].due) begin
        chk("missing_rsp", 0, 1);
        void'(sb.pop_front());
      end
      if (p0.req_ready || p1.req_ready) chk("ready_onehot", {31'b0, p0.req_ready & p1.req_ready}, 0);
      if (p0.req_valid && p0.req_ready) sb.push_back('{1'b0, p0.req_write, p0.req_addr, p0.req_wdata, cyc + 2});
      if (p1.req_valid && p1.req_ready) sb.push_back('{1'b1, p1.req_write, p1.req_addr, p1.req_wdata, cyc + 2});
    end
  end
  task automatic req(input bit port, input bit wr, input logic [8:0] a, input logic [31:0] d);
    bit got;
    got = 0;
    if (port) begin p1.req_valid = 1; p1.req_write = wr; p1.req_addr = a; p1.req_wdata = d; end
    else begin p0.req_valid = 1; p0.req_write = wr; p0.req_addr = a; p0.req_wdata = d; end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = port ? p1.req_ready : p0.req_ready;
    end
    if (!got) chk("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (port) p1.req_valid = 0;
    else p0.req_valid = 0;
  endtask
  typedef struct {
    logic v0, w0; logic [8:0] a0; logic [31:0] d0;
    logic v1, w1; logic [8:0] a1; logic [31:0] d1;
    logic r0, r1, fr0, fr1;
  } vec_t;
  vec_t vec [8];
  initial begin
    vec[0] = '{1, 1, 9'h020, 32'h1111_0000, 1, 0, 9'h020, 32'h0, 1, 0, 1, 0};
    vec[1] = '{1, 1, 9'h021, 32'h2222_0000, 1, 0, 9'h020, 32'h0, 0, 0, 0, 0};
    vec[2] = '{1, 1, 9'h021, 32'h2222_0000, 1, 0, 9'h020, 32'h0, 0, 1, 1, 0};
    vec[3] = '{1, 1, 9'h021, 32'h2222_0000, 1, 0, 9'h021, 32'h0, 0, 0, 0, 0};
    vec[4] = '{1, 1, 9'h021, 32'h2222_0000, 1, 0, 9'h021, 32'h0, 1, 0, 1, 0};
    vec[5] = '{1, 0, 9'h020, 32'h0,         1, 0, 9'h021, 32'h0, 0, 0, 0, 0};
    vec[6] = '{1, 0, 9'h020, 32'h0,         1, 0, 9'h021, 32'h0, 0, 1, 1, 0};
    vec[7] = '{1, 0, 9'h020, 32'h0,         1, 1, 9'h022, 32'h5, 0, 0, 0, 0};
    p0.req_valid = 1; p0.req_write = 1; p0.req_addr = 9'h1AA; p0.req_wdata = 32'hFFFF_FFFF;
    p1.req_valid = 0; p1.req_write = 0; p1.req_addr = '0; p1.req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready0", {31'b0, p0.req_ready}, 0);
    chk("rst_mem_we", {31'b0, mem_we}, 0);
    chk("rst_mem_addr", {23'b0, mem_addr}, 0);
    chk("rst_rsp_valid0", {31'b0, p0.rsp_valid}, 0);
    chk("rst_rsp_rdata0", p0.rsp_rdata, 0);
    @(posedge clk);
    #1;
    reset = 0;
    clr = 0;
    for (int i = 0; i < 8; i++) begin
      p0.req_valid = vec[i].v0; p0.req_write = vec[i].w0; p0.req_addr = vec[i].a0; p0.req_wdata = vec[i].d0;
      p1.req_valid = vec[i].v1; p1.req_write = vec[i].w1; p1.req_addr = vec[i].a1; p1.req_wdata = vec[i].d1;
      @(negedge clk);
      chk($sformatf("rr_ready0[%0d]", i), {31'b0, p0.req_ready}, {31'b0, vec[i].r0});
      chk($sformatf("rr_ready1[%0d]", i), {31'b0, p1.req_ready}, {31'b0, vec[i].r1});
      chk($sformatf("fp_ready0[%0d]", i), {31'b0, q0.req_ready}, {31'b0, vec[i].fr0});
      chk($sformatf("fp_ready1[%0d]", i), {31'b0, q1.req_ready}, {31'b0, vec[i].fr1});
      @(posedge clk);
      #1;
    end
    p0.req_valid = 0;
    p1.req_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    req(0, 1, 9'h010, 32'hDEAD_BEEF);
    @(negedge clk);
    @(negedge clk);
    chk("t1_wr_rsp_valid", {31'b0, p0.rsp_valid}, 1);
    chk("t1_wr_rsp_rdata", p0.rsp_rdata, 0);
    @(posedge clk);
    #1;
    req(0, 0, 9'h010, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("t1_rd_rsp_valid", {31'b0, p0.rsp_valid}, 1);
    chk("t1_rd_rsp_rdata", p0.rsp_rdata, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    p0.req_valid = 1; p0.req_write = 0; p0.req_addr = 9'h1FF; p0.req_wdata = '0;
    p1.req_valid = 1; p1.req_write = 1; p1.req_addr = 9'h1FF; p1.req_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("t4_p1_ready", {31'b0, p1.req_ready}, 1);
    chk("t4_p0_wait", {31'b0, p0.req_ready}, 0);
    @(posedge clk);
    #1;
    p1.req_valid = 0;
    @(negedge clk);
    chk("t4_busy_we", {31'b0, mem_we}, 1);
    @(negedge clk);
    chk("t4_p0_ready", {31'b0, p0.req_ready}, 1);
    @(posedge clk);
    #1;
    p0.req_valid = 0;
    @(negedge clk);
    @(negedge clk);
    chk("t4_rsp_valid0", {31'b0, p0.rsp_valid}, 1);
    chk("t4_rsp_rdata0", p0.rsp_rdata, 32'h1234_5678);
    @(posedge clk);
    #1;
    p1.req_valid = 1; p1.req_write = 1; p1.req_addr = 9'h033; p1.req_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("t6_p1_ready", {31'b0, p1.req_ready}, 1);
    @(posedge clk);
    #1;
    p1.req_valid = 0;
    p0.req_valid = 1; p0.req_write = 0; p0.req_addr = 9'h040;
    @(negedge clk);
    chk("t6_p0_wait", {31'b0, p0.req_ready}, 0);
    @(posedge clk);
    #1;
    p0.req_addr = 9'h033;
    @(negedge clk);
    chk("t6_p0_ready", {31'b0, p0.req_ready}, 1);
    @(posedge clk);
    #1;
    p0.req_valid = 0;
    p0.req_addr = 9'h077;
    @(negedge clk);
    chk("t6_mem_addr", {23'b0, mem_addr}, 32'h033);
    @(negedge clk);
    chk("t6_rsp_rdata0", p0.rsp_rdata, 32'hCAFE_F00D);
    @(posedge clk);
    #1;
    p0.req_valid = 1; p0.req_write = 1; p0.req_addr = 9'h005; p0.req_wdata = 32'hAAAA_5555;
    @(negedge clk);
    chk("t5_ready0", {31'b0, p0.req_ready}, 1);
    @(posedge clk);
    #1;
    p0.req_valid = 0;
    reset = 1;
    @(negedge clk);
    chk("t5_mem_we", {31'b0, mem_we}, 0);
    chk("t5_rsp_busy", {31'b0, p0.rsp_valid}, 0);
    @(posedge clk);
    #1;
    reset = 0;
    @(negedge clk);
    chk("t5_no_rsp", {31'b0, p0.rsp_valid}, 0);
    chk("t5_mem_addr", {23'b0, mem_addr}, 0);
    @(negedge clk);
    chk("t5_no_rsp_late", {31'b0, p0.rsp_valid}, 0);
    chk("t5_mem_unchanged", mem[5], 0);
    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
